// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory target for the core's load/store path.
// One request at a time, a fixed number of wait states, then a single-edge
// commit (store write or load capture) and a held response until accepted.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_next;

  logic accept;
  logic commit;
  logic req_err;

  logic             wr_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic [31:0]      wdata_q;
  logic [3:0]       count;

  logic [31:0] mem [DEPTH];

  logic             c_wr;
  logic             c_err;
  logic [IDX_W-1:0] c_idx;
  logic [1:0]       c_lane;
  logic [1:0]       c_size;
  logic [31:0]      c_wdata;
  logic [3:0]       c_be;
  logic [31:0]      c_data;

  // The signedness bit of the func3 size is meaningless to a raw-word memory.
  logic unused_size_bit;
  assign unused_size_bit = req_size[2];

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    req_err = 1'b0;
    case (req_size[1:0])
      2'b11:   req_err = 1'b1;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b0;
    endcase
    if (req_addr[31:2] >= DEPTH_W) req_err = 1'b1;
  end

  // With zero wait states the commit happens on the accept edge, so take the live inputs there.
  always_comb begin
    c_wr    = wr_q;
    c_err   = err_q;
    c_idx   = idx_q;
    c_lane  = lane_q;
    c_size  = size_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_wr    = req_wr;
      c_err   = req_err;
      c_idx   = req_addr[IDX_W+1:2];
      c_lane  = req_addr[1:0];
      c_size  = req_size[1:0];
      c_wdata = req_wdata;
    end
  end

  // Turn size and low address bits into byte enables plus lane-replicated store data.
  always_comb begin
    c_be   = 4'b1111;
    c_data = c_wdata;
    case (c_size)
      2'b00: begin
        c_be   = 4'b0001 << c_lane;
        c_data = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        c_be   = c_lane[1] ? 4'b1100 : 4'b0011;
        c_data = {2{c_wdata[15:0]}};
      end
      default: begin
        c_be   = 4'b1111;
        c_data = c_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, handshake outputs and the accept/commit strobes.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait counter, memory array and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      wdata_q   <= 32'h0;
      count     <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        err_q   <= req_err;
        idx_q   <= req_addr[IDX_W+1:2];
        lane_q  <= req_addr[1:0];
        size_q  <= req_size[1:0];
        wdata_q <= req_wdata;
        count   <= LAT_INIT;
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (commit) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= c_err;
        if (!c_err) begin
          if (c_wr) begin
            for (int b = 0; b < 4; b++) begin
              if (c_be[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
          end else begin
            rsp_rdata <= mem[c_idx];
          end
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder for the RISC-V core's load/store interface: the target end of the processor's data access path.
- Accepts one load or store request at a time through a valid/ready handshake.
- Inserts a configurable number of wait states, then commits the store or captures the load word, and returns a response through a second valid/ready handshake.
- Serves as the data memory for the planned multi-cycle and pipelined cores, replacing the zero-latency combinational memory.

Parameters:
- DEPTH, 256, number of 32-bit words; byte address range is 0 to 4*DEPTH-1.
- LATENCY, 2, wait-state cycles between request acceptance and response (0 to 15).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_wr  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  3  func3 encoding; [1:0] 00 byte, 01 half, 10 word, 11 illegal; [2] (unsigned) ignored here
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  raw aligned word for loads; 0 for stores and errors
- rsp_err  output  1  request was misaligned, out of range, or illegal size

Behaviour:
- Reset:
  - state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All memory words zeroed.
  - req_ready=1 from the first cycle after reset is deasserted.
- req_ready = (state==IDLE). It is a pure function of state, not of req_valid.
- FSM states:
  - IDLE -> on req_valid && req_ready, latch wr, addr, wdata, size and the error flag.
    - If LATENCY>0, go to BUSY with counter=LATENCY-1.
    - If LATENCY=0, commit and go straight to RESP.
  - BUSY -> decrement the counter each cycle. When counter==0, commit and go to RESP.
  - RESP -> rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready, then go to IDLE.
    - A new request can be accepted no earlier than the cycle after the response handshake; there is no overlap.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
- Commit (single edge, on entry to RESP):
  - Word index = addr[31:2].
  - Load: rsp_rdata = mem[index], full word, with no shifting or extension; the requester handles lane select and sign.
  - Store byte: lane addr[1:0] written with wdata[7:0].
  - Store half: lanes {addr[1],0} and {addr[1],1} written with wdata[15:0] (low lane gets [7:0]).
  - Store word: all four lanes written.
  - Unwritten lanes are preserved. Store response: rsp_rdata=0, rsp_err=0.
- Error (evaluated at accept):
  - Conditions: size[1:0]==11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2] >= DEPTH.
  - Effect: no memory write; rsp_err=1, rsp_rdata=0. Full latency still applies.
- Inputs are sampled only on the accept edge; changes while in BUSY or RESP are ignored.
- Holding rsp_ready=0 stalls in RESP indefinitely with outputs stable. rsp_ready while not in RESP is ignored.
- Reset mid-operation: an uncommitted store is dropped; any pending response is discarded; memory is zeroed.
- Read-after-write: a load accepted after a store's response handshake sees the new data.

Test Plan:
- Reset, LATENCY=2; store word 0xDEADBEEF to 0x10, rsp_ready=1 -> accept at cycle t, rsp_valid at t+3 for 1 cycle, rsp_err=0; load 0x10 -> rsp_rdata=0xDEADBEEF.
- After the above, store byte 0x5A to 0x12, then store half 0x1234 to 0x10; load 0x10 -> 0xDE5A1234.
- Error cases, each followed by a load of 0x10 returning 0xDE5A1234 (memory unchanged):
  - store word to 0x11 -> rsp_err=1
  - store half to 0x13 -> rsp_err=1
  - size=011 -> rsp_err=1
  - addr=4*DEPTH (0x400) -> rsp_err=1
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; after the handshake, req_ready=1 the next cycle.
- LATENCY=0 build: load accepted at cycle t -> rsp_valid at t+1; back-to-back requests with req_valid held high -> one accept every 2 cycles.
- Reset asserted in BUSY of a store 0xFFFFFFFF to 0x20 -> rsp_valid never rises; req_ready=1 after reset; load 0x20 -> 0x00000000.
